// File: rtl/rob_inst_buffer.sv
// rob_inst_buffer: reorder buffer for the AXIL OCL instruction path.
// Instructions enqueue in order, dispatch in order to the iNTT units,
// complete out of order by tag and retire in order.
// Optional feature: define ROB_OVF_CNT_EN to count dropped (full) writes in ovf_cnt.
module rob_inst_buffer #(
    parameter int unsigned PTR_W     = 3,
    parameter int unsigned OPCODE_W  = 4,
    parameter int unsigned INTT_ID_W = 2,
    parameter int unsigned LWE_W     = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [OPCODE_W-1:0]  wr_opcode,
    input  logic [2:0]           wr_gate,
    input  logic [INTT_ID_W-1:0] wr_intt_id,
    input  logic [LWE_W-1:0]     wr_init_value,
    input  logic [3:0]           wr_subs_factor,
    output logic                 full,
    output logic                 empty,
    output logic [PTR_W:0]       count,
    output logic                 disp_valid,
    input  logic                 disp_ready,
    output logic [PTR_W-1:0]     disp_tag,
    output logic [OPCODE_W-1:0]  disp_opcode,
    output logic [2:0]           disp_gate,
    output logic [INTT_ID_W-1:0] disp_intt_id,
    output logic [LWE_W-1:0]     disp_init_value,
    output logic [3:0]           disp_subs_factor,
    input  logic                 done_valid,
    input  logic [PTR_W-1:0]     done_tag,
    output logic                 ret_valid,
    input  logic                 ret_ready,
    output logic [OPCODE_W-1:0]  ret_opcode,
    output logic [2:0]           ret_gate,
    output logic [INTT_ID_W-1:0] ret_intt_id,
    output logic                 tag_err,
    output logic [15:0]          ovf_cnt
);

    localparam int unsigned DEPTH = 1 << PTR_W;
    localparam int unsigned CNT_W = PTR_W + 1;

    // Entry storage; contents are don't-care until written, so no reset.
    logic [OPCODE_W-1:0]  opcode_mem [0:DEPTH-1];
    logic [2:0]           gate_mem   [0:DEPTH-1];
    logic [INTT_ID_W-1:0] intt_mem   [0:DEPTH-1];
    logic [LWE_W-1:0]     init_mem   [0:DEPTH-1];
    logic [3:0]           subs_mem   [0:DEPTH-1];

    logic [DEPTH-1:0] done_q;
    logic [CNT_W-1:0] tail_q;
    logic [CNT_W-1:0] disp_q;
    logic [CNT_W-1:0] head_q;
    logic             tag_err_q;

    logic [PTR_W-1:0] tail_idx;
    logic [PTR_W-1:0] disp_idx;
    logic [PTR_W-1:0] head_idx;
    logic [CNT_W-1:0] occ;
    logic [CNT_W-1:0] inflight;
    logic [PTR_W-1:0] done_off;
    logic             wr_fire;
    logic             disp_fire;
    logic             ret_fire;
    logic             done_ok;
    logic             done_bad;

    // Occupancy, handshakes and completion legality, all from pre-edge state.
    always_comb begin
        tail_idx   = tail_q[PTR_W-1:0];
        disp_idx   = disp_q[PTR_W-1:0];
        head_idx   = head_q[PTR_W-1:0];
        occ        = tail_q - head_q;
        inflight   = disp_q - head_q;
        done_off   = done_tag - head_idx;
        full       = (occ == CNT_W'(DEPTH));
        empty      = (tail_q == head_q);
        count      = occ;
        disp_valid = (disp_q != tail_q);
        ret_valid  = (head_q != disp_q) && done_q[head_idx];
        wr_fire    = wr_en && !full;
        disp_fire  = disp_valid && disp_ready;
        ret_fire   = ret_valid && ret_ready;
        done_ok    = done_valid && ({1'b0, done_off} < inflight) && !done_q[done_tag];
        done_bad   = done_valid && !done_ok;
    end

    // Dispatch and retire views of the stored entries.
    always_comb begin
        disp_tag         = disp_idx;
        disp_opcode      = opcode_mem[disp_idx];
        disp_gate        = gate_mem[disp_idx];
        disp_intt_id     = intt_mem[disp_idx];
        disp_init_value  = init_mem[disp_idx];
        disp_subs_factor = subs_mem[disp_idx];
        ret_opcode       = opcode_mem[head_idx];
        ret_gate         = gate_mem[head_idx];
        ret_intt_id      = intt_mem[head_idx];
        tag_err          = tag_err_q;
    end

    // Entry field write at the tail slot.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            opcode_mem[tail_idx] <= wr_opcode;
            gate_mem[tail_idx]   <= wr_gate;
            intt_mem[tail_idx]   <= wr_intt_id;
            init_mem[tail_idx]   <= wr_init_value;
            subs_mem[tail_idx]   <= wr_subs_factor;
        end
    end

    // Pointers, done bits and sticky completion error.
    always_ff @(posedge clk) begin
        if (rst) begin
            tail_q    <= '0;
            disp_q    <= '0;
            head_q    <= '0;
            done_q    <= '0;
            tag_err_q <= 1'b0;
        end else begin
            if (wr_fire) begin
                tail_q           <= tail_q + CNT_W'(1);
                done_q[tail_idx] <= 1'b0;
            end
            if (disp_fire) begin
                disp_q <= disp_q + CNT_W'(1);
            end
            if (ret_fire) begin
                head_q <= head_q + CNT_W'(1);
            end
            // The tail slot is never in flight while a write is accepted.
            if (done_ok) begin
                done_q[done_tag] <= 1'b1;
            end
            if (done_bad) begin
                tag_err_q <= 1'b1;
            end
        end
    end

`ifdef ROB_OVF_CNT_EN
    logic [15:0] ovf_q;

    // Saturating count of writes dropped because the buffer was full.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= '0;
        end else if (wr_en && full && (ovf_q != 16'hFFFF)) begin
            ovf_q <= ovf_q + 16'd1;
        end
    end

    assign ovf_cnt = ovf_q;
`else
    assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_rob_inst_buffer.sv
// Directed testbench for rob_inst_buffer (default parameters, 8 entries).
module tb_rob_inst_buffer;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_opcode;
    logic [2:0]  wr_gate;
    logic [1:0]  wr_intt_id;
    logic [8:0]  wr_init_value;
    logic [3:0]  wr_subs_factor;
    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic        disp_valid;
    logic        disp_ready;
    logic [2:0]  disp_tag;
    logic [3:0]  disp_opcode;
    logic [2:0]  disp_gate;
    logic [1:0]  disp_intt_id;
    logic [8:0]  disp_init_value;
    logic [3:0]  disp_subs_factor;
    logic        done_valid;
    logic [2:0]  done_tag;
    logic        ret_valid;
    logic        ret_ready;
    logic [3:0]  ret_opcode;
    logic [2:0]  ret_gate;
    logic [1:0]  ret_intt_id;
    logic        tag_err;
    logic [15:0] ovf_cnt;

    int checks = 0;
    int errors = 0;

`ifdef ROB_OVF_CNT_EN
    localparam int OVF_STEP = 1;
`else
    localparam int OVF_STEP = 0;
`endif

    rob_inst_buffer dut (
        .clk              (clk),
        .rst              (rst),
        .wr_en            (wr_en),
        .wr_opcode        (wr_opcode),
        .wr_gate          (wr_gate),
        .wr_intt_id       (wr_intt_id),
        .wr_init_value    (wr_init_value),
        .wr_subs_factor   (wr_subs_factor),
        .full             (full),
        .empty            (empty),
        .count            (count),
        .disp_valid       (disp_valid),
        .disp_ready       (disp_ready),
        .disp_tag         (disp_tag),
        .disp_opcode      (disp_opcode),
        .disp_gate        (disp_gate),
        .disp_intt_id     (disp_intt_id),
        .disp_init_value  (disp_init_value),
        .disp_subs_factor (disp_subs_factor),
        .done_valid       (done_valid),
        .done_tag         (done_tag),
        .ret_valid        (ret_valid),
        .ret_ready        (ret_ready),
        .ret_opcode       (ret_opcode),
        .ret_gate         (ret_gate),
        .ret_intt_id      (ret_intt_id),
        .tag_err          (tag_err),
        .ovf_cnt          (ovf_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] exp_init(input int op);
        return 9'(op * 7 + 100);
    endfunction

    function automatic logic [3:0] exp_subs(input int op);
        return 4'(15 - (op % 16));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int op);
        wr_en          = 1'b1;
        wr_opcode      = 4'(op);
        wr_gate        = 3'(op);
        wr_intt_id     = 2'(op);
        wr_init_value  = exp_init(op);
        wr_subs_factor = exp_subs(op);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic complete(input int tag);
        done_valid = 1'b1;
        done_tag   = 3'(tag);
        tick();
        done_valid = 1'b0;
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        wr_en          = 1'b0;
        wr_opcode      = '0;
        wr_gate        = '0;
        wr_intt_id     = '0;
        wr_init_value  = '0;
        wr_subs_factor = '0;
        disp_ready     = 1'b0;
        done_valid     = 1'b0;
        done_tag       = '0;
        ret_ready      = 1'b0;

        // Reset state.
        reset_pulse();
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_disp_valid", 32'(disp_valid), 32'd0);
        check("rst_ret_valid", 32'(ret_valid), 32'd0);
        check("rst_tag_err", 32'(tag_err), 32'd0);
        check("rst_ovf", 32'(ovf_cnt), 32'd0);

        // Three writes; first visible on dispatch port the next cycle.
        wr(1);
        check("w1_disp_valid", 32'(disp_valid), 32'd1);
        check("w1_count", 32'(count), 32'd1);
        wr(2);
        wr(3);
        check("w3_count", 32'(count), 32'd3);
        check("w3_disp_tag", 32'(disp_tag), 32'd0);
        check("w3_disp_opcode", 32'(disp_opcode), 32'd1);
        check("w3_disp_gate", 32'(disp_gate), 32'd1);
        check("w3_disp_intt", 32'(disp_intt_id), 32'd1);
        check("w3_disp_init", 32'(disp_init_value), 32'(exp_init(1)));
        check("w3_disp_subs", 32'(disp_subs_factor), 32'(exp_subs(1)));

        // Dispatch tags 0,1,2.
        disp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("disp_tag", 32'(disp_tag), 32'(i));
            check("disp_opcode", 32'(disp_opcode), 32'(i + 1));
            tick();
        end
        disp_ready = 1'b0;
        check("disp_drained", 32'(disp_valid), 32'd0);
        check("pre_done_ret", 32'(ret_valid), 32'd0);

        // Out-of-order completion 2, 0, duplicate 0, then 1.
        complete(2);
        check("c2_ret_valid", 32'(ret_valid), 32'd0);
        check("c2_tag_err", 32'(tag_err), 32'd0);
        complete(0);
        check("c0_ret_valid", 32'(ret_valid), 32'd1);
        check("c0_ret_opcode", 32'(ret_opcode), 32'd1);
        check("c0_ret_gate", 32'(ret_gate), 32'd1);
        check("c0_ret_intt", 32'(ret_intt_id), 32'd1);
        check("c0_tag_err", 32'(tag_err), 32'd0);
        complete(0);
        check("dup_tag_err", 32'(tag_err), 32'd1);
        check("dup_ret_valid", 32'(ret_valid), 32'd1);
        check("dup_ret_opcode", 32'(ret_opcode), 32'd1);
        check("dup_count", 32'(count), 32'd3);
        complete(1);

        // In-order retire.
        ret_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("ret_valid", 32'(ret_valid), 32'd1);
            check("ret_opcode", 32'(ret_opcode), 32'(i + 1));
            tick();
        end
        ret_ready = 1'b0;
        check("ret_done_valid", 32'(ret_valid), 32'd0);
        check("ret_done_empty", 32'(empty), 32'd1);

        // Undispatched completion, fill to full, overflow.
        reset_pulse();
        check("b_tag_err_clr", 32'(tag_err), 32'd0);
        for (int op = 1; op <= 6; op++) wr(op);
        disp_ready = 1'b1;
        tick();
        tick();
        disp_ready = 1'b0;
        complete(5);
        check("undisp_tag_err", 32'(tag_err), 32'd1);
        check("undisp_ret_valid", 32'(ret_valid), 32'd0);
        wr(7);
        check("w7_full", 32'(full), 32'd0);
        check("w7_count", 32'(count), 32'd7);
        wr(8);
        check("w8_full", 32'(full), 32'd1);
        check("w8_count", 32'(count), 32'd8);
        check("w8_empty", 32'(empty), 32'd0);
        wr(9);
        check("w9_count", 32'(count), 32'd8);
        check("w9_full", 32'(full), 32'd1);
        check("w9_ovf", 32'(ovf_cnt), 32'(OVF_STEP));
        check("w9_disp_tag", 32'(disp_tag), 32'd2);
        check("w9_disp_opcode", 32'(disp_opcode), 32'd3);
        complete(0);
        check("full_ret_valid", 32'(ret_valid), 32'd1);
        check("full_ret_opcode", 32'(ret_opcode), 32'd1);

        // Full buffer: write dropped even with a same-cycle retire.
        wr_en     = 1'b1;
        wr_opcode = 4'd10;
        ret_ready = 1'b1;
        tick();
        wr_en     = 1'b0;
        ret_ready = 1'b0;
        check("sim_count", 32'(count), 32'd7);
        check("sim_full", 32'(full), 32'd0);
        check("sim_ovf", 32'(ovf_cnt), 32'(2 * OVF_STEP));
        check("sim_ret_valid", 32'(ret_valid), 32'd0);
        check("sim_disp_tag", 32'(disp_tag), 32'd2);

        // 20 full rounds wrapping the pointers, then reset mid-stream.
        reset_pulse();
        check("c_ovf_clr", 32'(ovf_cnt), 32'd0);
        for (int r = 0; r < 20; r++) begin
            wr(r % 16);
            check("rnd_disp_tag", 32'(disp_tag), 32'(r % 8));
            check("rnd_disp_opcode", 32'(disp_opcode), 32'(r % 16));
            disp_ready = 1'b1;
            tick();
            disp_ready = 1'b0;
            complete(r % 8);
            check("rnd_ret_valid", 32'(ret_valid), 32'd1);
            check("rnd_ret_opcode", 32'(ret_opcode), 32'(r % 16));
            ret_ready = 1'b1;
            tick();
            ret_ready = 1'b0;
        end
        check("rnd_tag_err", 32'(tag_err), 32'd0);
        check("rnd_empty", 32'(empty), 32'd1);
        wr(3);
        wr(4);
        disp_ready = 1'b1;
        tick();
        disp_ready = 1'b0;
        check("pre_rst_count", 32'(count), 32'd2);
        rst        = 1'b1;
        done_valid = 1'b1;
        done_tag   = 3'd4;
        tick();
        done_tag   = 3'd7;
        tick();
        rst        = 1'b0;
        done_valid = 1'b0;
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_disp_valid", 32'(disp_valid), 32'd0);
        check("mid_rst_ret_valid", 32'(ret_valid), 32'd0);
        check("mid_rst_tag_err", 32'(tag_err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_ret_valid", 32'(ret_valid), 32'd0);
            check("post_rst_disp_valid", 32'(disp_valid), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rob_inst_buffer.md
ROB_INST_BUFFER -- requirements
Module: rob_inst_buffer

Interface
REQ-001 SHALL have parameters (name, default, meaning): PTR_W, 3, log2 of entry count (8 entries).
REQ-002 SHALL have parameter OPCODE_W, 4, opcode width.
REQ-003 SHALL have parameter INTT_ID_W, 2, iNTT unit id width.
REQ-004 SHALL have parameter LWE_W, 9, LWE init value width.
REQ-005 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-007 SHALL have port wr_en, input, 1, enqueue strobe from the AXIL OCL instruction path.
REQ-008 SHALL have port wr_opcode/wr_gate/wr_intt_id/wr_init_value/wr_subs_factor, input, OPCODE_W/3/INTT_ID_W/LWE_W/4, instruction fields.
REQ-009 SHALL have port full/empty, output, 1 each, occupancy flags.
REQ-010 SHALL have port count, output, PTR_W+1, occupied entries.
REQ-011 SHALL have port disp_valid/disp_ready, output/input, 1 each, dispatch handshake toward iNTT units.
REQ-012 SHALL have port disp_tag, output, PTR_W, entry index of dispatched instruction; disp_opcode/gate/intt_id/init_value/subs_factor, output, field widths.
REQ-013 SHALL have port done_valid, input, 1, and done_tag, input, PTR_W: out-of-order completion report.
REQ-014 SHALL have port ret_valid/ret_ready, output/input, 1 each, in-order retire handshake; ret_opcode/ret_gate/ret_intt_id, output, field widths.
REQ-015 SHALL have port tag_err, output, 1, sticky illegal-completion flag.
REQ-016 SHALL have port ovf_cnt, output, 16, dropped-write counter (see Configuration).

Function
REQ-017 SHALL store entries in a circular array with three pointers: tail (write), disp (next to dispatch), head (next to retire), each PTR_W+1 bits incl. wrap bit.
REQ-018 SHALL per entry hold fields plus done bit; done cleared on write.
REQ-019 SHALL accept write when wr_en && !full; entry at tail written, tail+1; written entry visible on disp port next cycle.
REQ-020 SHALL drop write when wr_en && full (full evaluated on pre-edge state, even if retire occurs same cycle); no state change except overflow counting.
REQ-021 SHALL drive disp_valid = (disp != tail); disp_* fields and disp_tag = disp[PTR_W-1:0] combinationally from stored entry; disp advances on disp_valid && disp_ready.
REQ-022 SHALL set done of entry done_tag when done_valid and entry is dispatched-not-retired (between head and disp) and not already done; otherwise set tag_err=1, state unchanged.
REQ-023 SHALL drive ret_valid = (head != disp) && done[head]; ret_* from head entry; head advances on ret_valid && ret_ready.
REQ-024 SHALL allow write, dispatch, completion and retire all in one cycle; completion of head entry in cycle N makes ret_valid high in N+1 (1-cycle latency).
REQ-025 SHALL compute full = (tail-head == 2^PTR_W), empty = (tail == head), count = tail-head, all mod 2^(PTR_W+1), from registered pointers.
REQ-026 SHALL never let disp pass tail nor head pass disp; pointer wrap via MSB toggle.

Reset
REQ-027 SHALL on rst=1 at clock edge zero all pointers, done bits, tag_err, ovf_cnt; outputs: empty=1, full=0, count=0, disp_valid=0, ret_valid=0.
REQ-028 SHALL on reset mid-operation discard all in-flight entries; completions arriving while rst=1 ignored and not flagged.
REQ-029 SHALL not require storage array reset (fields don't-care when invalid).

Configuration
REQ-030 SHALL, with ROB_OVF_CNT_EN defined, increment ovf_cnt on each dropped write, saturating at 16'hFFFF.
REQ-031 SHALL, without ROB_OVF_CNT_EN, tie ovf_cnt to 0 and include no counter logic.

Verification
REQ-032 SHALL cover: reset, write 3 entries (opcodes 1,2,3) -> count=3, disp_valid=1 next cycle with disp_tag=0, opcode=1.
REQ-033 SHALL cover: dispatch tags 0,1,2, complete 2 then 0 then 1 -> ret order opcode 1,2,3; ret_valid low until tag 0 done.
REQ-034 SHALL cover: 9 writes with no retire -> full=1 after 8th, 9th dropped, ovf_cnt=1 (macro on) / 0 (off).
REQ-035 SHALL cover: full buffer, head done, simultaneous wr_en and ret handshake -> write dropped, count=7 next cycle.
REQ-036 SHALL cover: done_tag for undispatched entry 5 and duplicate completion of tag 0 -> tag_err=1, ret stream unchanged.
REQ-037 SHALL cover: 20 write/dispatch/complete/retire rounds wrapping pointers twice, rst asserted mid-stream -> empty=1, count=0, no ret_valid afterward.
